vp_key_event_queue: RTL and testbench

- Replaces the ad hoc PS/2/joystick-to-ASCII merge logic in front of vp_keymap.
- Accepts PS/2 key events and the numpad fields from N_JOY gamepads, and detects per-key press/release edges.
- Queues events in a small FIFO and presents them one at a time to vp_keymap through a valid/ack handshake.
- Fixes the "stuck key" problem: every joystick press gets a matching release, and events that arrive together are never dropped.

---
 rtl/vp_input_pkg.sv | 26 ++
 rtl/vp_event_fifo.sv | 69 ++++++
 rtl/vp_key_event_queue.sv | 180 ++++++++++++++++++
 tb/tb_vp_key_event_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vp_input_pkg.sv
// ---------------------------------------------------------------------------
// vp_input_pkg
// Shared types and helpers for the keyboard/gamepad input path that feeds
// vp_keymap.
//   key_event_t  : one queued key event {released, ascii}
//   digit_ascii  : numpad bit index (0..9) -> ASCII digit ("1".."9","0")
//   NUMPAD_W     : width of one gamepad numpad field
//   ASCII_NONE   : PS/2 code meaning "no mapping", never queued
// ---------------------------------------------------------------------------
package vp_input_pkg;

   localparam int         NUMPAD_W   = 10;
   localparam logic [7:0] ASCII_NONE = 8'h00;

   typedef struct packed {
      logic       released;
      logic [7:0] ascii;
   } key_event_t;

   // Numpad bit 9 is the "0" key, bits 0..8 are "1".."9".
   function automatic logic [7:0] digit_ascii(input int i);
      if (i >= 9) return 8'h30;
      return 8'h31 + 8'(i);
   endfunction

endpackage

// File: rtl/vp_event_fifo.sv
// ---------------------------------------------------------------------------
// vp_event_fifo
// Show-ahead synchronous FIFO with an exact occupancy count.
//   clk_sys, reset : clock, asynchronous active-high reset
//   wr_en, wr_data : push request and data
//   wr_ready       : push would be accepted this cycle (not full, or a pop
//                    happens in the same cycle)
//   rd_en          : pop request, ignored while empty
//   rd_valid       : head entry valid
//   rd_data        : head entry (zero while empty)
//   level          : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module vp_event_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      full     = (level == LW'(DEPTH));
      empty    = (level == '0);
      do_pop   = rd_en && !empty;
      wr_ready = !full || do_pop;
      do_push  = wr_en && wr_ready;
      rd_valid = !empty;
      rd_data  = empty ? '0 : mem[rd_ptr];
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (!do_push && do_pop) level <= level - LW'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/vp_key_event_queue.sv
// ---------------------------------------------------------------------------
// vp_key_event_queue
// Merges PS/2 key events and gamepad numpad keys into one event queue for
// vp_keymap. Gamepad keys are OR-merged across channels, edge detected and
// held as pending press/release bits until the scanner can queue them, so
// every reported press gets its release and nothing is lost while full.
//   clk_sys, reset   : clock, asynchronous active-high reset
//   ps2_strobe_i     : one-cycle PS/2 event strobe
//   ps2_ascii_i      : PS/2 ASCII code (0x00 = unmapped, dropped)
//   ps2_released_i   : PS/2 event is a key release
//   joy_numpad_i     : N_JOY numpad fields, 10 bits each, 1 = pressed
//   ev_valid_o       : head event valid
//   ev_ascii_o       : head event ASCII code
//   ev_released_o    : head event is a release
//   ev_ack_i         : pop head event
//   level_o          : queue occupancy
//   overflow_o       : sticky, a PS/2 event was dropped
// ---------------------------------------------------------------------------
module vp_key_event_queue
   import vp_input_pkg::*;
#(
   parameter int N_JOY    = 2,
   parameter int DEPTH    = 8,
   parameter bit PS2_PRIO = 1'b1
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic                        ps2_strobe_i,
   input  logic [7:0]                  ps2_ascii_i,
   input  logic                        ps2_released_i,
   input  logic [N_JOY*NUMPAD_W-1:0]   joy_numpad_i,
   output logic                        ev_valid_o,
   output logic [7:0]                  ev_ascii_o,
   output logic                        ev_released_o,
   input  logic                        ev_ack_i,
   output logic [$clog2(DEPTH):0]      level_o,
   output logic                        overflow_o
);

   logic [NUMPAD_W-1:0] merged, cur, prev, rise, fall;
   logic [NUMPAD_W-1:0] pend_press, pend_rel, next_press, next_rel;
   logic [NUMPAD_W-1:0] clr_press, clr_rel, p_left, r_left;
   logic                scan_req, scan_rel, scan_take;
   logic [3:0]          scan_idx;
   logic                ps2_valid, skid_valid, skid_load, skid_clear, ps2_drop;
   logic                push_en, push_ready;
   key_event_t          scan_ev, ps2_ev, skid_ev, push_ev, head_ev;

   // A key only counts as released once no channel holds it any more.
   always_comb begin
      merged = '0;
      for (int c = 0; c < N_JOY; c++)
         merged = merged | joy_numpad_i[c*NUMPAD_W +: NUMPAD_W];
   end

   // Lowest pending index wins; a pending press on an index goes before
   // its pending release.
   always_comb begin
      scan_req = 1'b0;
      scan_rel = 1'b0;
      scan_idx = '0;
      for (int i = NUMPAD_W-1; i >= 0; i--) begin
         if (pend_press[i] || pend_rel[i]) begin
            scan_req = 1'b1;
            scan_idx = 4'(i);
            scan_rel = !pend_press[i];
         end
      end
      scan_ev.released = scan_rel;
      scan_ev.ascii    = digit_ascii(int'(scan_idx));
   end

   // One push per cycle. With PS2_PRIO the PS/2 event takes the slot and
   // the scanner waits; otherwise the scanner wins and the PS/2 event is
   // parked in the skid register, which then goes first on the next cycle.
   always_comb begin
      ps2_valid       = ps2_strobe_i && (ps2_ascii_i != ASCII_NONE);
      ps2_ev.released = ps2_released_i;
      ps2_ev.ascii    = ps2_ascii_i;
      push_en         = 1'b0;
      push_ev         = '0;
      scan_take       = 1'b0;
      skid_load       = 1'b0;
      skid_clear      = 1'b0;
      ps2_drop        = 1'b0;
      if (PS2_PRIO) begin
         if (ps2_valid) begin
            push_en  = 1'b1;
            push_ev  = ps2_ev;
            ps2_drop = !push_ready;
         end else if (scan_req) begin
            push_en   = 1'b1;
            push_ev   = scan_ev;
            scan_take = push_ready;
         end
      end else begin
         if (skid_valid) begin
            push_en    = 1'b1;
            push_ev    = skid_ev;
            skid_clear = push_ready;
            ps2_drop   = ps2_valid;
         end else if (scan_req) begin
            push_en   = 1'b1;
            push_ev   = scan_ev;
            scan_take = push_ready;
            skid_load = ps2_valid;
         end else if (ps2_valid) begin
            push_en  = 1'b1;
            push_ev  = ps2_ev;
            ps2_drop = !push_ready;
         end
      end
   end

   // Pending update: the scanner's consumption is applied first, then the
   // new edges. An edge opposite to a still-pending one cancels it, so a
   // quick tap that was never reported stays unreported.
   always_comb begin
      rise      = cur & ~prev;
      fall      = ~cur & prev;
      clr_press = (scan_take && !scan_rel) ? (NUMPAD_W'(1) << scan_idx) : '0;
      clr_rel   = (scan_take &&  scan_rel) ? (NUMPAD_W'(1) << scan_idx) : '0;
      p_left    = pend_press & ~clr_press;
      r_left    = pend_rel & ~clr_rel;
      next_press = p_left;
      next_rel   = r_left;
      for (int i = 0; i < NUMPAD_W; i++) begin
         if (rise[i]) begin
            next_rel[i]   = 1'b0;
            next_press[i] = p_left[i] || !r_left[i];
         end else if (fall[i]) begin
            next_press[i] = 1'b0;
            next_rel[i]   = r_left[i] || !p_left[i];
         end
      end
   end

   // Input register, edge history, pending masks, skid and overflow flag.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cur        <= '0;
         prev       <= '0;
         pend_press <= '0;
         pend_rel   <= '0;
         skid_valid <= 1'b0;
         skid_ev    <= '0;
         overflow_o <= 1'b0;
      end else begin
         cur        <= merged;
         prev       <= cur;
         pend_press <= next_press;
         pend_rel   <= next_rel;
         if (skid_clear) skid_valid <= 1'b0;
         if (skid_load) begin
            skid_valid <= 1'b1;
            skid_ev    <= ps2_ev;
         end
         if (ps2_drop) overflow_o <= 1'b1;
      end
   end

   vp_event_fifo #(
      .WIDTH ($bits(key_event_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .wr_en    (push_en),
      .wr_data  (push_ev),
      .wr_ready (push_ready),
      .rd_en    (ev_ack_i),
      .rd_valid (ev_valid_o),
      .rd_data  (head_ev),
      .level    (level_o)
   );

   assign ev_ascii_o    = head_ev.ascii;
   assign ev_released_o = head_ev.released;

endmodule

// File: tb/tb_vp_key_event_queue.sv
// ---------------------------------------------------------------------------
// tb_vp_key_event_queue
// Directed self-checking bench for vp_key_event_queue (N_JOY=2, DEPTH=8,
// PS2_PRIO=1). Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_vp_key_event_queue;

   logic        clk_sys;
   logic        reset;
   logic        ps2_strobe_i;
   logic [7:0]  ps2_ascii_i;
   logic        ps2_released_i;
   logic [19:0] joy_numpad_i;
   logic        ev_valid_o;
   logic [7:0]  ev_ascii_o;
   logic        ev_released_o;
   logic        ev_ack_i;
   logic [3:0]  level_o;
   logic        overflow_o;

   int compared;
   int mismatched;

   vp_key_event_queue #(
      .N_JOY    (2),
      .DEPTH    (8),
      .PS2_PRIO (1'b1)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ps2_strobe_i   (ps2_strobe_i),
      .ps2_ascii_i    (ps2_ascii_i),
      .ps2_released_i (ps2_released_i),
      .joy_numpad_i   (joy_numpad_i),
      .ev_valid_o     (ev_valid_o),
      .ev_ascii_o     (ev_ascii_o),
      .ev_released_o  (ev_released_o),
      .ev_ack_i       (ev_ack_i),
      .level_o        (level_o),
      .overflow_o     (overflow_o)
   );

   // 100 MHz system clock.
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Drive the PS/2 and consumer-side inputs for the next edge.
   task automatic applyStimulus(input logic strobe, input logic [7:0] ascii,
                                input logic rel, input logic ack);
      ps2_strobe_i   = strobe;
      ps2_ascii_i    = ascii;
      ps2_released_i = rel;
      ev_ack_i       = ack;
   endtask

   // One comparison: counts it and reports a mismatch with tag and values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h",
                tag, observed, expected);
      end
   endtask

   // Check the whole head-of-queue view in one call.
   task automatic checkHead(input string tag, input logic valid,
                            input logic [7:0] ascii, input logic rel,
                            input logic [3:0] level);
      checkOutput({tag, ".valid"}, 32'(ev_valid_o), 32'(valid));
      checkOutput({tag, ".ascii"}, 32'(ev_ascii_o), 32'(ascii));
      checkOutput({tag, ".rel"},   32'(ev_released_o), 32'(rel));
      checkOutput({tag, ".level"}, 32'(level_o), 32'(level));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      joy_numpad_i = '0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      #3;
      checkHead("reset", 1'b0, 8'h00, 1'b0, 4'd0);
      checkOutput("reset.overflow", 32'(overflow_o), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(1);

      $display("[TB] PS/2 event 'a' and ack");
      applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("ps2_a", 1'b1, 8'h61, 1'b0, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("ps2_a_ack", 1'b0, 8'h00, 1'b0, 4'd0);

      $display("[TB] unmapped PS/2 code is discarded");
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1);
      checkOutput("ps2_none.level", 32'(level_o), 32'd0);

      $display("[TB] joystick ch0 key 3 press and release");
      joy_numpad_i = 20'h00004;
      tick(2);
      checkOutput("joy3_early.valid", 32'(ev_valid_o), 32'd0);
      tick(1);
      checkHead("joy3_press", 1'b1, 8'h33, 1'b0, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("joy3_press_ack.level", 32'(level_o), 32'd0);
      joy_numpad_i = 20'h00000;
      tick(3);
      checkHead("joy3_release", 1'b1, 8'h33, 1'b1, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("joy3_release_ack.level", 32'(level_o), 32'd0);

      $display("[TB] key 0 held on both channels");
      joy_numpad_i = {10'h200, 10'h200};
      tick(3);
      checkHead("joy0_press", 1'b1, 8'h30, 1'b0, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      joy_numpad_i = {10'h200, 10'h000};
      tick(4);
      checkOutput("joy0_ch0_up.level", 32'(level_o), 32'd0);
      joy_numpad_i = 20'h00000;
      tick(3);
      checkHead("joy0_release", 1'b1, 8'h30, 1'b1, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("joy0_release_ack.level", 32'(level_o), 32'd0);

      $display("[TB] fill queue, overflow, tap while full");
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b1, 8'h41 + 8'(n), 1'b0, 1'b0);
         tick(1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("fill.level", 32'(level_o), 32'd8);
      checkOutput("fill.overflow", 32'(overflow_o), 32'd0);
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("drop", 1'b1, 8'h41, 1'b0, 4'd8);
      checkOutput("drop.overflow", 32'(overflow_o), 32'd1);
      joy_numpad_i = 20'h00001;
      tick(1);
      joy_numpad_i = 20'h00000;
      tick(4);
      checkOutput("tap_full.level", 32'(level_o), 32'd8);
      applyStimulus(1'b1, 8'h62, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("push_pop_full", 1'b1, 8'h42, 1'b0, 4'd8);
      checkOutput("push_pop_full.overflow", 32'(overflow_o), 32'd1);
      for (int n = 0; n < 7; n++) begin
         checkOutput("drain.ascii", 32'(ev_ascii_o), 32'(8'h42 + 8'(n)));
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
         tick(1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("drain_last", 1'b1, 8'h62, 1'b0, 4'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick(4);
      checkHead("tap_cancelled", 1'b0, 8'h00, 1'b0, 4'd0);

      $display("[TB] PS/2 and joystick collide, then reset mid-queue");
      joy_numpad_i = {10'h010, 10'h000};
      tick(2);
      applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("collide_ps2", 1'b1, 8'h71, 1'b0, 4'd1);
      tick(1);
      checkOutput("collide_joy.level", 32'(level_o), 32'd2);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkHead("collide_joy", 1'b1, 8'h35, 1'b0, 4'd1);
      reset = 1'b1;
      #1;
      checkHead("async_reset", 1'b0, 8'h00, 1'b0, 4'd0);
      checkOutput("async_reset.overflow", 32'(overflow_o), 32'd0);
      tick(1);
      reset = 1'b0;
      tick(3);
      checkHead("held_after_reset", 1'b1, 8'h35, 1'b0, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
